// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential 32x32 unsigned shift-and-add multiplier around a shared ripple-carry adder

module adder_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        C0,
    output logic [31:0] sum,
    output logic        Overflow
);
    always_comb begin : ripple
        logic [32:0] c;
        c        = '0;
        sum      = '0;
        c[0]     = C0;
        for (int i = 0; i < 32; i++) begin
            sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Overflow = c[32];
    end
endmodule

module mult_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [31:0] add_sum;
    logic        add_carry;
    logic        accept;

    adder_32bit u_adder (
        .A        (hi_q),
        .B        (mcand_q),
        .C0       (1'b0),
        .sum      (add_sum),
        .Overflow (add_carry)
    );

    // A start is only honoured when the unit is not iterating.
    assign accept = start && (state_q != ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == 5'd31) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        if (accept) begin
            mcand_d = A;
            hi_d    = '0;
            lo_d    = B;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            // The adder carry-out lands in HI[31] after the right shift.
            if (lo_q[0]) begin
                {hi_d, lo_d} = {add_carry, add_sum, lo_q[31:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
            end
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
        HI   = hi_q;
        LO   = lo_q;
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - table-driven bench for mult_seq

module tb_mult_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mult_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Launch one multiply, count busy cycles and check the result at done.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        logic [63:0] prod;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'd32);
        check("done_pulse", {63'd0, done}, 64'd1);
        check("product", {HI, LO}, {exp_hi, exp_lo});
        prod = {HI, LO};
        @(negedge clk);
        check("done_single", {62'd0, busy, done}, 64'd0);
        check("hold_after_done", {HI, LO}, prod);
    endtask

    initial begin
        int n;
        int prev;
        int ndone;
        bit saw_done;

        vecs[0] = '{32'd3,         32'd5,         32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'h80000000,  32'd2,         32'h00000001, 32'h00000000};
        vecs[3] = '{32'h12345678,  32'd0,         32'h00000000, 32'h00000000};
        vecs[4] = '{32'd0,         32'h9ABCDEF0,  32'h00000000, 32'h00000000};
        vecs[5] = '{32'h0000FFFF,  32'h0000FFFF,  32'h00000000, 32'hFFFE0001};
        vecs[6] = '{32'h00010000,  32'h00010000,  32'h00000001, 32'h00000000};

        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {30'd0, busy, done, HI, LO}, 66'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++)
            run_mult(vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

        // Start pulses while busy must be ignored.
        @(negedge clk);
        A = 32'd7; B = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 10) begin start = 1'b1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; end
            if (n == 13) begin start = 1'b0; end
            @(negedge clk);
        end
        check("ignored_start_busy", 64'(n), 64'd32);
        check("ignored_start_done", {63'd0, done}, 64'd1);
        check("ignored_start_prod", {HI, LO}, 64'h2A);
        @(negedge clk);

        // Reset in the middle of RUN aborts with no done pulse.
        A = 32'h0000FFFF; B = 32'h0000FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 16) begin
            n++;
            @(negedge clk);
        end
        check("busy_before_abort", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_state", {30'd0, busy, done, HI, LO}, 66'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("no_done_after_abort", {63'd0, saw_done}, 64'd0);
        run_mult(32'd2, 32'd9, 32'd0, 32'h12);

        // Back-to-back with start held high.
        @(negedge clk);
        A = 32'd10; B = 32'd10; start = 1'b1;
        prev = -1;
        ndone = 0;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_product", {HI, LO}, 64'h64);
                if (prev >= 0) check("b2b_period", 64'(i - prev), 64'd33);
                prev = i;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 64'(ndone), 64'd3);
        n = 0;
        while ((busy || done) && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("b2b_final", {HI, LO}, 64'h64);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
